mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 158 +++++++++++++++
 tb/tb_mult_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester round-robin front end for a shared fixed-latency
// A*A+97*B pipeline. Issued ops are tracked by a {valid, tag} shift register
// that mirrors the pipeline depth, so each result is routed back to its owner.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing in flight, grants allowed
// BUSY   | at least one op in flight, grants allowed
// DRAIN  | flush seen; no grants until flush drops and pipeline empty
module mult_arbiter #(
   parameter int LATENCY = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               req0_valid,
   input  logic signed [7:0]  req0_a,
   input  logic signed [7:0]  req0_b,
   input  logic               req1_valid,
   input  logic signed [7:0]  req1_a,
   input  logic signed [7:0]  req1_b,
   output logic               req0_ready,
   output logic               req1_ready,
   input  logic               flush,
   output logic signed [7:0]  mult_a,
   output logic signed [7:0]  mult_b,
   input  logic signed [15:0] mult_result,
   output logic               rsp0_valid,
   output logic               rsp1_valid,
   output logic signed [15:0] rsp_data,
   output logic [3:0]         outstanding,
   output logic               idle
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 ptr;
   logic                 grant;
   logic                 gnt_id;
   logic [LATENCY-1:0]   pipe_vld;
   logic [LATENCY-1:0]   pipe_tag;
   logic                 retire;
   logic                 rsp_hit;
   logic [3:0]           cnt;
   logic [3:0]           cnt_nxt;

   assign retire = pipe_vld[LATENCY-1];

   // Arbitration: a single valid wins outright, a tie goes to the pointer.
   always_comb begin
      grant  = 1'b0;
      gnt_id = 1'b0;
      if (!RESET && (state != ST_DRAIN) && !flush) begin
         if (req0_valid && req1_valid) begin
            grant  = 1'b1;
            gnt_id = ptr;
         end else if (req0_valid) begin
            grant  = 1'b1;
            gnt_id = 1'b0;
         end else if (req1_valid) begin
            grant  = 1'b1;
            gnt_id = 1'b1;
         end
      end
   end

   // Operand mux toward the pipeline and response routing from its tail.
   always_comb begin
      req0_ready = grant && !gnt_id;
      req1_ready = grant && gnt_id;
      mult_a     = '0;
      mult_b     = '0;
      if (grant) begin
         mult_a = gnt_id ? req1_a : req0_a;
         mult_b = gnt_id ? req1_b : req0_b;
      end
      rsp_hit    = !RESET && retire;
      rsp0_valid = rsp_hit && !pipe_tag[LATENCY-1];
      rsp1_valid = rsp_hit && pipe_tag[LATENCY-1];
      rsp_data   = rsp_hit ? mult_result : '0;
   end

   // In-flight count: issue and retire in the same cycle cancel out.
   always_comb begin
      cnt_nxt = cnt;
      if (grant && !retire) begin
         cnt_nxt = cnt + 4'd1;
      end else if (!grant && retire) begin
         cnt_nxt = cnt - 4'd1;
      end
   end

   // Next-state logic; flush outranks a grant in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (flush) begin
               state_nxt = ST_DRAIN;
            end else if (grant) begin
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               state_nxt = ST_DRAIN;
            end else if (!grant && (cnt_nxt == 4'd0)) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!flush && (cnt_nxt == 4'd0)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, round-robin pointer and in-flight counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
         ptr   <= 1'b0;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (grant) begin
            ptr <= ~gnt_id;
         end
      end
   end

   // Tag shift register tracking each op through the pipeline.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pipe_vld <= '0;
         pipe_tag <= '0;
      end else begin
         pipe_vld[0] <= grant;
         pipe_tag[0] <= gnt_id;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   assign outstanding = cnt;
   assign idle        = (state == ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed scenarios plus randomized traffic, checked against
// a queue-based model of ops in flight with their due cycles.
module tb_mult_arbiter;

   localparam int LATENCY = 4;

   logic               CLK = 1'b1;
   logic               RESET = 1'b1;
   logic               req0_valid = 1'b0;
   logic signed [7:0]  req0_a = '0;
   logic signed [7:0]  req0_b = '0;
   logic               req1_valid = 1'b0;
   logic signed [7:0]  req1_a = '0;
   logic signed [7:0]  req1_b = '0;
   logic               flush = 1'b0;
   logic               req0_ready;
   logic               req1_ready;
   logic signed [7:0]  mult_a;
   logic signed [7:0]  mult_b;
   logic signed [15:0] mult_result;
   logic               rsp0_valid;
   logic               rsp1_valid;
   logic signed [15:0] rsp_data;
   logic [3:0]         outstanding;
   logic               idle;

   mult_arbiter #(.LATENCY(LATENCY)) dut (
      .CLK(CLK), .RESET(RESET),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .flush(flush),
      .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .outstanding(outstanding), .idle(idle)
   );

   always #5 CLK = ~CLK;

   // Shared pipeline stand-in: A*A+97*B, LATENCY stages, same reset.
   logic signed [15:0] mpipe [LATENCY];
   always @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < LATENCY; i++) mpipe[i] <= '0;
      end else begin
         mpipe[0] <= 16'(int'(mult_a) * int'(mult_a) + 97 * int'(mult_b));
         for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign mult_result = mpipe[LATENCY-1];

   typedef struct {
      int                 left;
      bit                 id;
      logic signed [15:0] val;
   } op_t;

   op_t q[$];
   bit  m_ptr;
   bit  m_drain;
   bit  model_ok;
   int  n_checks;
   int  n_errors;

   logic               obs_rdy0, obs_rdy1, obs_rsp0, obs_rsp1, obs_idle;
   logic signed [15:0] obs_data;
   logic [3:0]         obs_out;

   task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [15:0] ref_val(logic signed [7:0] a, logic signed [7:0] b);
      int ai;
      int bi;
      ai = a;
      bi = b;
      return 16'(ai * ai + 97 * bi);
   endfunction

   // One clock cycle: drive, check mid-cycle against the model, advance the model.
   task automatic step(bit v0, logic signed [7:0] a0, logic signed [7:0] b0,
                       bit v1, logic signed [7:0] a1, logic signed [7:0] b1,
                       bit fl, bit rst);
      bit                 g;
      bit                 gid;
      bit                 hit;
      bit                 e0;
      bit                 e1;
      logic signed [7:0]  ea;
      logic signed [7:0]  eb;
      logic signed [15:0] ed;
      op_t                op;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      flush = fl;
      RESET = rst;
      g   = !rst && !m_drain && !fl && (v0 || v1);
      gid = (v0 && v1) ? m_ptr : v1;
      ea  = g ? (gid ? a1 : a0) : 8'sd0;
      eb  = g ? (gid ? b1 : b0) : 8'sd0;
      hit = !rst && (q.size() > 0) && (q[0].left == 0);
      e0  = hit && !q[0].id;
      e1  = hit && q[0].id;
      ed  = hit ? q[0].val : 16'sd0;
      @(negedge CLK);
      check_eq("req0_ready", 32'(req0_ready), 32'(g && !gid));
      check_eq("req1_ready", 32'(req1_ready), 32'(g && gid));
      check_eq("mult_a", 32'(mult_a), 32'(ea));
      check_eq("mult_b", 32'(mult_b), 32'(eb));
      check_eq("rsp0_valid", 32'(rsp0_valid), 32'(e0));
      check_eq("rsp1_valid", 32'(rsp1_valid), 32'(e1));
      check_eq("rsp_data", 32'(rsp_data), 32'(ed));
      if (model_ok) begin
         check_eq("outstanding", 32'(outstanding), 32'(q.size()));
         check_eq("idle", 32'(idle), 32'(!m_drain && (q.size() == 0)));
      end
      obs_rdy0 = req0_ready; obs_rdy1 = req1_ready;
      obs_rsp0 = rsp0_valid; obs_rsp1 = rsp1_valid;
      obs_data = rsp_data;   obs_out  = outstanding; obs_idle = idle;
      @(posedge CLK);
      if (rst) begin
         q.delete();
         m_ptr    = 1'b0;
         m_drain  = 1'b0;
         model_ok = 1'b1;
      end else begin
         if (hit) void'(q.pop_front());
         foreach (q[i]) q[i].left = q[i].left - 1;
         if (g) begin
            op.left = LATENCY - 1;
            op.id   = gid;
            op.val  = gid ? ref_val(a1, b1) : ref_val(a0, b0);
            q.push_back(op);
            m_ptr = !gid;
         end
         m_drain = fl || (m_drain && (q.size() != 0));
      end
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic reset_step();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      int peak;
      int nrsp;
      int fl_hold;
      n_checks = 0;
      n_errors = 0;
      model_ok = 1'b0;
      m_ptr    = 1'b0;
      m_drain  = 1'b0;

      // Reset and quiescent state
      repeat (3) reset_step();
      idle_step();
      check_eq("rst_out", 32'(obs_out), 32'd0);
      check_eq("rst_idle", 32'(obs_idle), 32'd1);

      // Single op from req0: 3*3 + 97*2 = 203
      step(1'b1, 8'sd3, 8'sd2, 1'b0, '0, '0, 1'b0, 1'b0);
      check_eq("single_rdy0", 32'(obs_rdy0), 32'd1);
      for (int i = 1; i <= LATENCY; i++) begin
         idle_step();
         check_eq("single_out", 32'(obs_out), 32'd1);
      end
      check_eq("single_rsp0", 32'(obs_rsp0), 32'd1);
      check_eq("single_data", 32'(obs_data), 32'd203);
      idle_step();
      check_eq("single_out_end", 32'(obs_out), 32'd0);

      // Both valid after reset: req0 first, then req1
      reset_step();
      step(1'b1, 8'sh80, 8'sh80, 1'b1, 8'sh7f, 8'sh7f, 1'b0, 1'b0);
      check_eq("tie_rdy0", 32'(obs_rdy0), 32'd1);
      check_eq("tie_rdy1", 32'(obs_rdy1), 32'd0);
      step(1'b0, '0, '0, 1'b1, 8'sh7f, 8'sh7f, 1'b0, 1'b0);
      check_eq("tie_rdy1_next", 32'(obs_rdy1), 32'd1);
      repeat (LATENCY - 2) idle_step();
      idle_step();
      check_eq("tie_rsp0", 32'(obs_rsp0), 32'd1);
      check_eq("tie_data0", 32'(obs_data), 32'd3968);
      idle_step();
      check_eq("tie_rsp1", 32'(obs_rsp1), 32'd1);
      check_eq("tie_data1", 32'(obs_data), 32'd28448);

      // Eight back-to-back contended cycles: alternation and tag order
      reset_step();
      peak = 0;
      nrsp = 0;
      for (int i = 0; i < 8 + LATENCY + 2; i++) begin
         if (i < 8) begin
            step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            check_eq("alt_rdy0", 32'(obs_rdy0), 32'((i % 2) == 0));
         end else begin
            idle_step();
         end
         if (int'(obs_out) > peak) peak = int'(obs_out);
         if (obs_rsp0 || obs_rsp1) begin
            check_eq("alt_tag", 32'(obs_rsp1), 32'(nrsp % 2));
            nrsp++;
         end
      end
      check_eq("alt_count", 32'(nrsp), 32'd8);
      check_eq("alt_peak", 32'(peak), 32'(LATENCY));

      // Flush with three ops in flight
      reset_step();
      repeat (3) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      nrsp = 0;
      for (int i = 0; i < LATENCY + 2; i++) begin
         step(1'b1, 8'sd5, 8'sd5, 1'b1, 8'sd6, 8'sd6, 1'b1, 1'b0);
         check_eq("flush_rdy", 32'(obs_rdy0 || obs_rdy1), 32'd0);
         check_eq("flush_idle", 32'(obs_idle), 32'd0);
         if (obs_rsp0) nrsp++;
      end
      check_eq("flush_rsp_count", 32'(nrsp), 32'd3);
      step(1'b1, 8'sd5, 8'sd5, 1'b0, '0, '0, 1'b0, 1'b0);
      check_eq("drain_last_rdy", 32'(obs_rdy0), 32'd0);
      idle_step();
      check_eq("drain_exit_idle", 32'(obs_idle), 32'd1);

      // Reset with an op in flight discards it and resets the pointer
      reset_step();
      step(1'b1, 8'sd1, 8'sd1, 1'b0, '0, '0, 1'b0, 1'b0);
      idle_step();
      reset_step();
      nrsp = 0;
      for (int i = 0; i < LATENCY + 2; i++) begin
         idle_step();
         if (i == 0) check_eq("midrst_out", 32'(obs_out), 32'd0);
         if (obs_rsp0 || obs_rsp1) nrsp++;
      end
      check_eq("midrst_norsp", 32'(nrsp), 32'd0);
      step(1'b1, 8'sd7, 8'sd7, 1'b1, 8'sd9, 8'sd9, 1'b0, 1'b0);
      check_eq("midrst_rdy0", 32'(obs_rdy0), 32'd1);

      // Randomized traffic with occasional flush spans and resets
      fl_hold = 0;
      for (int c = 0; c < 3000; c++) begin
         bit rst_now;
         bit fl_now;
         rst_now = ($urandom_range(0, 299) == 0);
         if ((fl_hold == 0) && ($urandom_range(0, 49) == 0)) fl_hold = $urandom_range(1, 8);
         fl_now = (fl_hold > 0);
         if (fl_hold > 0) fl_hold--;
         step($urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
              $urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom),
              fl_now, rst_now);
      end
      repeat (LATENCY + 2) idle_step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
